// File: rtl/led_rx_decoder.sv
// Pulse-width decoder for a single-wire LED chain: recovers 24-bit pixels,
// flags framing errors and forwards the stream once its own pixel is taken.
module led_rx_decoder #(
    parameter int BIT_THRESH   = 62,
    parameter int MIN_HIGH     = 8,
    parameter int HIGH_TIMEOUT = 250,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        din,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic        bit_error,
    output logic        dout
);

    localparam logic [15:0] BIT_T  = 16'(BIT_THRESH);
    localparam logic [15:0] MIN_H  = 16'(MIN_HIGH);
    localparam logic [15:0] TO_M1  = 16'(HIGH_TIMEOUT - 1);
    localparam logic [15:0] LAT_M1 = 16'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        s1;
    logic        s2;
    logic        s3;
    logic        rise;
    logic        fall;
    logic [15:0] cnt_high;
    logic [15:0] cnt_low;
    logic [4:0]  bit_cnt;
    logic [23:0] shreg;

    logic        bit_val;
    logic        glitch;
    logic        timeout;
    logic        latch;

    logic        ev_shift;
    logic        ev_pix;
    logic        ev_err;
    logic        ev_frame;
    logic        ev_discard;
    logic        ev_clr_idx;
    logic        fwd;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // s1/s2 resolve metastability; s3 only serves edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign bit_val = (cnt_high >= BIT_T);
    assign glitch  = fall && (cnt_high < MIN_H);
    assign timeout = s2 && (cnt_high >= TO_M1);
    assign latch   = !s2 && (cnt_low >= LAT_M1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            SYNC: begin
                if (latch) state_nx = IDLE;
            end
            IDLE: begin
                if (rise) state_nx = HIGH;
            end
            HIGH: begin
                if (fall) state_nx = glitch ? SYNC : LOW;
                else if (timeout) state_nx = SYNC;
            end
            LOW: begin
                if (rise) state_nx = HIGH;
                else if (latch) state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        ev_shift   = 1'b0;
        ev_pix     = 1'b0;
        ev_err     = 1'b0;
        ev_frame   = 1'b0;
        ev_discard = 1'b0;
        ev_clr_idx = 1'b0;
        unique case (state)
            SYNC: begin
                ev_discard = 1'b1;
            end
            IDLE: begin
                ev_clr_idx = rise;
            end
            HIGH: begin
                if (fall) begin
                    if (glitch) begin
                        ev_err     = 1'b1;
                        ev_discard = 1'b1;
                    end else begin
                        ev_shift = 1'b1;
                        ev_pix   = (bit_cnt == 5'd23);
                    end
                end else if (timeout) begin
                    ev_err     = 1'b1;
                    ev_discard = 1'b1;
                end
            end
            LOW: begin
                if (latch) begin
                    ev_frame   = 1'b1;
                    ev_err     = (bit_cnt != 5'd0);
                    ev_discard = 1'b1;
                end
            end
        endcase
        fwd = ((state == HIGH) || (state == LOW)) && (pixel_index != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_high <= 16'd0;
            cnt_low  <= 16'd0;
        end else begin
            unique case (state)
                SYNC: begin
                    cnt_high <= 16'd0;
                    cnt_low  <= s2 ? 16'd0 : sat_inc(cnt_low);
                end
                IDLE: begin
                    cnt_high <= rise ? 16'd1 : 16'd0;
                    cnt_low  <= 16'd0;
                end
                HIGH: begin
                    cnt_high <= sat_inc(cnt_high);
                    cnt_low  <= fall ? 16'd1 : 16'd0;
                end
                LOW: begin
                    cnt_high <= rise ? 16'd1 : 16'd0;
                    cnt_low  <= sat_inc(cnt_low);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shreg       <= 24'd0;
            bit_cnt     <= 5'd0;
            pixel_data  <= 24'd0;
            pixel_valid <= 1'b0;
            pixel_index <= 8'd0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            dout        <= 1'b0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= ev_frame;
            bit_error   <= ev_err;
            dout        <= fwd & s2;
            if (ev_clr_idx) pixel_index <= 8'd0;
            if (ev_discard) begin
                shreg   <= 24'd0;
                bit_cnt <= 5'd0;
            end else if (ev_shift) begin
                shreg <= {shreg[22:0], bit_val};
                if (ev_pix) begin
                    pixel_data  <= {shreg[22:0], bit_val};
                    pixel_valid <= 1'b1;
                    bit_cnt     <= 5'd0;
                    if (pixel_index != 8'hFF) pixel_index <= pixel_index + 8'd1;
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule
